// File: rtl/ddr5_phy_pkg.sv
// Shared PHY definitions: serializer FSM encoding, last-phase index and the
// idle-level helper used by both the serializer and the deserializer.
package ddr5_phy_pkg;

  localparam logic       SER_IDLE   = 1'b0;
  localparam logic       SER_SHIFT  = 1'b1;
  localparam logic [1:0] PHASE_LAST = 2'd3;

  typedef enum logic {
    ST_IDLE  = SER_IDLE,
    ST_SHIFT = SER_SHIFT
  } ser_state_e;

  // Idle lane level: alert-style lanes rest high, data lanes rest low.
  function automatic logic idle_level(input int is_alert);
    return (is_alert != 0);
  endfunction

endpackage

// File: rtl/ddr5_ser_hold_buf.sv
// One-entry hold register in front of the serializer shift stage.
// With DDR5_SER_UNDERRUN_EN defined, the word's last_i flag travels alongside it.
module ddr5_ser_hold_buf
  import ddr5_phy_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  valid_i,
  input  logic [WIDTH-1:0]      p0_i,
  input  logic [WIDTH-1:0]      p1_i,
  input  logic [WIDTH-1:0]      p2_i,
  input  logic [WIDTH-1:0]      p3_i,
`ifdef DDR5_SER_UNDERRUN_EN
  input  logic                  last_i,
  output logic                  hold_last_o,
`endif
  input  logic                  pop_i,
  output logic                  ready_o,
  output logic                  hold_full_o,
  output logic [3:0][WIDTH-1:0] hold_data_o
);

  logic                  full_q, full_d;
  logic [3:0][WIDTH-1:0] data_q, data_d;
  logic                  accept;

  // A popping entry frees the slot in the same cycle, so a new word may land on it.
  assign ready_o = !rst_i && enable_i && (!full_q || pop_i);
  assign accept  = valid_i && ready_o;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = {p3_i, p2_i, p1_i, p0_i};
    end else if (enable_i && pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

`ifdef DDR5_SER_UNDERRUN_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (accept) last_d = last_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b0;
    else       last_q <= last_d;
  end

  assign hold_last_o = last_q;
`endif

  assign hold_full_o = full_q;
  assign hold_data_o = data_q;

endmodule

// File: rtl/ddr5_serializer_unit.sv
// 4:1 transmit serializer: one parallel word per handshake, p0 first, gap-free bursts.
// Optional sticky underrun detection when DDR5_SER_UNDERRUN_EN is defined.
module ddr5_serializer_unit
  import ddr5_phy_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int IS_ALERT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] p0_i,
  input  logic [WIDTH-1:0] p1_i,
  input  logic [WIDTH-1:0] p2_i,
  input  logic [WIDTH-1:0] p3_i,
`ifdef DDR5_SER_UNDERRUN_EN
  input  logic             last_i,
  input  logic             underrun_clr_i,
  output logic             underrun_o,
`endif
  output logic [WIDTH-1:0] serial_o,
  output logic [1:0]       phase_o,
  output logic             bit_valid_o,
  output logic             count_done_o
);

  localparam logic [WIDTH-1:0] IDLE_LVL = {WIDTH{idle_level(IS_ALERT)}};

  ser_state_e            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [3:0][WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0]      serial_q, serial_d;
  logic [1:0]            phase_q, phase_d;
  logic                  bv_q, bv_d;
  logic                  done_q, done_d;
  logic                  hold_full, hold_moves;
  logic [3:0][WIDTH-1:0] hold_data;

  assign hold_moves = hold_full &&
                      ((state_q == ST_IDLE) || ((state_q == ST_SHIFT) && (cnt_q == PHASE_LAST)));

`ifdef DDR5_SER_UNDERRUN_EN
  logic hold_last;
  logic active_last_q, active_last_d;
  logic under_q, under_d;
  logic under_set;
`endif

  ddr5_ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .valid_i     (valid_i),
    .p0_i        (p0_i),
    .p1_i        (p1_i),
    .p2_i        (p2_i),
    .p3_i        (p3_i),
`ifdef DDR5_SER_UNDERRUN_EN
    .last_i      (last_i),
    .hold_last_o (hold_last),
`endif
    .pop_i       (hold_moves),
    .ready_o     (ready_o),
    .hold_full_o (hold_full),
    .hold_data_o (hold_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    serial_d = serial_q;
    phase_d  = phase_q;
    bv_d     = bv_q;
    done_d   = done_q;
    if (enable_i) begin
      case (state_q)
        ST_IDLE: begin
          phase_d = 2'd0;
          done_d  = 1'b0;
          if (hold_full) begin
            active_d = hold_data;
            serial_d = hold_data[0];
            bv_d     = 1'b1;
            cnt_d    = 2'd1;
            state_d  = ST_SHIFT;
          end else begin
            serial_d = IDLE_LVL;
            bv_d     = 1'b0;
            cnt_d    = 2'd0;
          end
        end
        default: begin
          serial_d = active_q[cnt_q];
          phase_d  = cnt_q;
          bv_d     = 1'b1;
          done_d   = (cnt_q == PHASE_LAST);
          // cnt wraps to 0 after the last phase; reload keeps the burst going, else drain to IDLE.
          cnt_d    = cnt_q + 2'd1;
          if (cnt_q == PHASE_LAST) begin
            if (hold_full) active_d = hold_data;
            else           state_d  = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      active_q <= '0;
      serial_q <= IDLE_LVL;
      phase_q  <= 2'd0;
      bv_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      serial_q <= serial_d;
      phase_q  <= phase_d;
      bv_q     <= bv_d;
      done_q   <= done_d;
    end
  end

`ifdef DDR5_SER_UNDERRUN_EN
  assign under_set = enable_i && (state_q == ST_SHIFT) && (cnt_q == PHASE_LAST) &&
                     !hold_full && !active_last_q;

  always_comb begin
    active_last_d = active_last_q;
    under_d       = under_q;
    if (enable_i && hold_moves) active_last_d = hold_last;
    if (enable_i && underrun_clr_i) under_d = 1'b0;
    if (under_set) under_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_last_q <= 1'b0;
      under_q       <= 1'b0;
    end else begin
      active_last_q <= active_last_d;
      under_q       <= under_d;
    end
  end

  assign underrun_o = under_q;
`endif

  assign serial_o     = serial_q;
  assign phase_o      = phase_q;
  assign bit_valid_o  = bv_q;
  assign count_done_o = done_q;

endmodule
